ssd_capture: RTL

SSD_CAPTURE -- requirements
Module: ssd_capture

---
 rtl/ssd_capture.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ssd_capture.sv
// Recovers the 16-bit value shown on a multiplexed 4-digit seven-segment display.
// Define SSD_CAPTURE_TIMEOUT_EN to compile in the partial-frame watchdog.
module ssd_capture #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int REFRESH_RATE  = 200,
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  segment,
    input  logic [3:0]  anode,
    output logic [15:0] data_out,
    output logic [3:0]  blank_out,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        timeout,
    output logic [1:0]  fsm_state
);
    // Output handshake: frame_valid is a single-cycle strobe with no ready; the
    // frame outputs change only on that cycle and hold until the next strobe.

    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, HELD = 2'd2} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [7:0]  seg_meta, seg_sync, seg_eff;
    logic [3:0]  an_meta, an_sync, an_eff;
    logic [1:0]  primed;
    logic [11:0] prev_sample;
    logic        changed, an_valid, an_illegal;
    logic [1:0]  digit_idx;
    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic        capture;
    logic [3:0]  cap_bit;
    logic [5:0]  dec;
    logic [15:0] shadow_data;
    logic [3:0]  shadow_blank, shadow_dp, captured;
    logic        pend_err, frame_done, wd_expire, frame_clear;

    // Returns {undecodable, blank, nibble}.
    function automatic logic [5:0] decode_seg(input logic [6:0] pat);
        logic [5:0] r;
        r = 6'b10_0000;
        case (pat)
            7'h40: r = {2'b00, 4'h0};
            7'h79: r = {2'b00, 4'h1};
            7'h24: r = {2'b00, 4'h2};
            7'h30: r = {2'b00, 4'h3};
            7'h19: r = {2'b00, 4'h4};
            7'h12: r = {2'b00, 4'h5};
            7'h02: r = {2'b00, 4'h6};
            7'h78: r = {2'b00, 4'h7};
            7'h00: r = {2'b00, 4'h8};
            7'h10: r = {2'b00, 4'h9};
            7'h08: r = {2'b00, 4'hA};
            7'h03: r = {2'b00, 4'hB};
            7'h46: r = {2'b00, 4'hC};
            7'h21: r = {2'b00, 4'hD};
            7'h06: r = {2'b00, 4'hE};
            7'h0E: r = {2'b00, 4'hF};
            7'h7F: r = {2'b01, 4'h0};
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta <= '0;
            seg_sync <= '0;
            an_meta  <= '0;
            an_sync  <= '0;
            primed   <= '0;
        end else begin
            seg_meta <= segment;
            seg_sync <= seg_meta;
            an_meta  <= anode;
            an_sync  <= an_meta;
            primed   <= {primed[0], 1'b1};
        end
    end

    // Until the synchronizers hold a real pin sample, their reset zeros would
    // look like an illegal anode; present an idle display instead.
    assign an_eff  = primed[1] ? an_sync  : 4'b1111;
    assign seg_eff = primed[1] ? seg_sync : 8'hFF;
    assign changed = ({an_eff, seg_eff} != prev_sample);

    always_comb begin
        an_valid  = 1'b1;
        digit_idx = 2'd0;
        case (an_eff)
            4'b1110: digit_idx = 2'd0;
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: an_valid = 1'b0;
        endcase
    end

    assign an_illegal = !an_valid && (an_eff != 4'b1111);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // HELD only leaves on a change, so a dwell yields at most one capture.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (an_valid) begin
                    state_next = COUNT;
                    cnt_next   = 8'd1;
                end
            end
            COUNT, HELD: begin
                if (changed) begin
                    state_next = an_valid ? COUNT : IDLE;
                    cnt_next   = an_valid ? 8'd1 : 8'd0;
                end else if (state == COUNT) begin
                    cnt_next = cnt + 8'd1;
                    if (cnt_next == STABLE) begin
                        state_next = HELD;
                        capture    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    assign fsm_state   = state;
    assign dec         = decode_seg(seg_eff[6:0]);
    assign cap_bit     = capture ? (4'b0001 << digit_idx) : 4'b0000;
    assign frame_done  = &captured;
    assign frame_clear = frame_done || wd_expire;

    // Clearing and a fresh capture/error on the same edge keep the fresh one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sample  <= '0;
            shadow_data  <= '0;
            shadow_blank <= '0;
            shadow_dp    <= '0;
            captured     <= '0;
            pend_err     <= 1'b0;
            data_out     <= '0;
            blank_out    <= '0;
            dp_out       <= '0;
            frame_valid  <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            prev_sample <= {an_eff, seg_eff};
            if (capture) begin
                shadow_data[{digit_idx, 2'b00} +: 4] <= dec[3:0];
                shadow_blank[digit_idx]              <= dec[4];
                shadow_dp[digit_idx]                 <= ~seg_eff[7];
            end
            captured    <= (frame_clear ? 4'b0000 : captured) | cap_bit;
            pend_err    <= (frame_clear ? 1'b0 : pend_err) | an_illegal | (capture & dec[5]);
            frame_valid <= frame_done;
            if (frame_done) begin
                data_out    <= shadow_data;
                blank_out   <= shadow_blank;
                dp_out      <= shadow_dp;
                frame_error <= pend_err;
            end
        end
    end

`ifdef SSD_CAPTURE_TIMEOUT_EN
    localparam int WD_LIMIT = 4 * CLK_FREQUENCY / REFRESH_RATE;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt;

    // Saturates at the limit, so an abandoned partial frame keeps being discarded.
    assign wd_expire = (wd_cnt == WD_W'(WD_LIMIT)) && !capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (capture)
                wd_cnt <= '0;
            else if (wd_cnt != WD_W'(WD_LIMIT))
                wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_expire)
                timeout <= 1'b1;
            else if (frame_done)
                timeout <= 1'b0;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule
